mainfsm_ws: RTL and testbench
=============================

Name: mainfsm_ws

Overview:
- Next-generation main control FSM for the multicycle ARM datapath.
- Adds a memory ready/wait-state handshake with a timeout, an iterative multiply execute phase, and a sticky fault trap.
- Decodes Op/Funct/IsMul and drives the same datapath control bundle as the current controller, plus MemReq, MulStart and Fault.
- Sits in the controller next to the ALU decoder and conditional logic.

Parameters:
- MEM_HANDSHAKE, 1: 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = single-cycle memory, mem_ready ignored.
- MUL_CYCLES, 4: cycles spent in MULEX (>=1).
- TIMEOUT, 15: consecutive not-ready cycles in a memory state before trapping (>=1).
- CNT_W, 4: width of the wait/multiply counter; must hold max(TIMEOUT, MUL_CYCLES).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction op field.
- Funct  in  6  instruction funct field.
- IsMul  in  1  decoded multiply pattern (Op=00 only).
- mem_ready  in  1  memory completes access this cycle.
- IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  datapath controls.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects; ResultSrc=11 selects the multiplier result.
- MemReq  out  1  memory access request.
- MulStart  out  1  one-cycle pulse launching the multiplier.
- Fault  out  1  sticky trap indicator.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, MULEX=10, MULWB=11, FAULT=12.
- reset low: state=FETCH, counter=0, Fault=0. All outputs take their FETCH values immediately, asynchronously.
- "Ready" = mem_ready when MEM_HANDSHAKE=1, else constant 1.

Transitions:
- FETCH: ->DECODE on ready.
- DECODE:
  - Op=00 & IsMul -> MULEX.
  - Op=00 & Funct[5] -> EXECUTEI.
  - Op=00 otherwise -> EXECUTER.
  - Op=01 -> MEMADR.
  - Op=10 -> BRANCH.
  - Op=11 -> FAULT.
- MEMADR: Funct[0] ? MEMRD : MEMWR.
- MEMRD: ->MEMWB on ready.
- MEMWR: ->FETCH on ready.
- EXECUTER, EXECUTEI: ->ALUWB.
- MULEX: ->MULWB after exactly MUL_CYCLES cycles in the state.
- MEMWB, ALUWB, MULWB, BRANCH: ->FETCH.
- FAULT: stays in FAULT until reset.

Counter:
- Clears on every state change.
- In FETCH/MEMRD/MEMWR it increments each not-ready cycle. When it reaches TIMEOUT with ready still low, next state is FAULT.
- Ready in the same cycle the count hits TIMEOUT: ready wins.
- In MULEX it counts cycles.

Outputs (default 0 unless listed):
- FETCH: MemReq=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=1 only in the ready cycle.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: MemReq=1, AdrSrc=1.
- MEMWB: RegW=1, ResultSrc=01.
- MEMWR: MemReq=1, AdrSrc=1, MemW=1 for every cycle in the state. Memory commits on its ready cycle.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- MULEX: MulStart=1 only on the first cycle in the state.
- MULWB: RegW=1, ResultSrc=11.
- BRANCH: Branch=1, ResultSrc=10, ALUSrcA=10, ALUSrcB=01.
- FAULT: Fault=1; all writes (RegW, MemW, IRWrite, NextPC, Branch) and MemReq are 0.

Invariants:
- No write enable asserts in any unlisted state.
- Reset during a wait abandons the access: MemReq must not be asserted in any state other than FETCH/MEMRD/MEMWR.

Test Plan:
- Reset low mid-MEMWR, then release: state_o=0, MemW=0, MemReq=1 on the next cycle, Fault=0.
- MEM_HANDSHAKE=1, mem_ready low 3 cycles in FETCH then high: IRWrite/NextPC pulse exactly once, in cycle 4; DECODE follows.
- LDR (Op=01, Funct[0]=1) with mem_ready always 1: sequence 0,1,2,3,4,0; RegW=1 with ResultSrc=01 in MEMWB only.
- MUL (Op=00, IsMul=1), MUL_CYCLES=4: MULEX held 4 cycles, MulStart high only on cycle 1; MULWB gives RegW=1, ResultSrc=11.
- mem_ready stuck low in MEMRD, TIMEOUT=15: FAULT entered after 15 waiting cycles, Fault stays 1 for 20+ cycles with no writes; ready on the 15th cycle instead goes to MEMWB.
- Op=11 in DECODE -> FAULT next cycle. MEM_HANDSHAKE=0, STR (Op=01, Funct[0]=0): states 0,1,2,5,0 with MemW=1 for exactly one cycle.

Source files
------------

// File: rtl/mainfsm_ws.sv
// Main multicycle controller FSM with memory wait-state handshake, timeout trap,
// iterative multiply phase and a sticky fault state.
module mainfsm_ws #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MUL_CYCLES    = 4,
  parameter int TIMEOUT       = 15,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMul,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       MemReq,
  output logic       MulStart,
  output logic       Fault,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
    MULEX = 4'd10, MULWB = 4'd11, FAULT = 4'd12
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ready, mem_state, timed_out;
  logic             unused_funct;

  assign unused_funct = ^Funct[4:1];
  assign ready     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  // The count holds the number of not-ready cycles already spent, so this is the last allowed one.
  assign timed_out = !ready && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:    if (ready) state_nxt = DECODE; else if (timed_out) state_nxt = FAULT;
      DECODE: begin
        case (Op)
          2'b00:   state_nxt = IsMul ? MULEX : (Funct[5] ? EXECUTEI : EXECUTER);
          2'b01:   state_nxt = MEMADR;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = FAULT;
        endcase
      end
      MEMADR:   state_nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    if (ready) state_nxt = MEMWB; else if (timed_out) state_nxt = FAULT;
      MEMWR:    if (ready) state_nxt = FETCH; else if (timed_out) state_nxt = FAULT;
      EXECUTER, EXECUTEI: state_nxt = ALUWB;
      MULEX:    if (cnt == MUL_LAST) state_nxt = MULWB;
      MEMWB, ALUWB, MULWB, BRANCH: state_nxt = FETCH;
      FAULT:    state_nxt = FAULT;
      default:  state_nxt = FAULT;
    endcase
  end

  always_comb begin
    cnt_nxt = '0;
    if (state_nxt == state) begin
      if ((mem_state && !ready) || (state == MULEX)) cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    MemReq    = 1'b0;
    MulStart  = 1'b0;
    Fault     = 1'b0;
    case (state)
      FETCH: begin
        MemReq = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        IRWrite = ready; NextPC = ready;
      end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    begin MemReq = 1'b1; AdrSrc = 1'b1; end
      MEMWB:    begin RegW = 1'b1; ResultSrc = 2'b01; end
      MEMWR:    begin MemReq = 1'b1; AdrSrc = 1'b1; MemW = 1'b1; end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin ALUSrcB = 2'b01; ALUOp = 1'b1; end
      ALUWB:    RegW = 1'b1;
      MULEX:    MulStart = (cnt == '0);
      MULWB:    begin RegW = 1'b1; ResultSrc = 2'b11; end
      BRANCH:   begin Branch = 1'b1; ResultSrc = 2'b10; ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      FAULT:    Fault = 1'b1;
      default:  Fault = 1'b1;
    endcase
  end

  assign state_o = state;
endmodule

// File: tb/tb_mainfsm_ws.sv
// Directed scoreboard bench for mainfsm_ws: one handshake instance, one single-cycle-memory instance.
module tb_mainfsm_ws;
  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IsMul, mem_ready;

  logic       ir_a, adr_a, npc_a, regw_a, memw_a, br_a, aluop_a, mreq_a, ms_a, flt_a;
  logic [1:0] sa_a, sb_a, rs_a;
  logic [3:0] st_a;
  logic       ir_b, adr_b, npc_b, regw_b, memw_b, br_b, aluop_b, mreq_b, ms_b, flt_b;
  logic [1:0] sa_b, sb_b, rs_b;
  logic [3:0] st_b;
  logic [19:0] obs_a, obs_b;

  logic [19:0] sb[$];
  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mainfsm_ws #(.MEM_HANDSHAKE(1), .MUL_CYCLES(4), .TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .reset(rst_a), .Op(Op), .Funct(Funct), .IsMul(IsMul), .mem_ready(mem_ready),
    .IRWrite(ir_a), .AdrSrc(adr_a), .NextPC(npc_a), .RegW(regw_a), .MemW(memw_a),
    .Branch(br_a), .ALUOp(aluop_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ResultSrc(rs_a),
    .MemReq(mreq_a), .MulStart(ms_a), .Fault(flt_a), .state_o(st_a));

  mainfsm_ws #(.MEM_HANDSHAKE(0), .MUL_CYCLES(4), .TIMEOUT(15), .CNT_W(4)) dut0 (
    .clk(clk), .reset(rst_b), .Op(Op), .Funct(Funct), .IsMul(IsMul), .mem_ready(mem_ready),
    .IRWrite(ir_b), .AdrSrc(adr_b), .NextPC(npc_b), .RegW(regw_b), .MemW(memw_b),
    .Branch(br_b), .ALUOp(aluop_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ResultSrc(rs_b),
    .MemReq(mreq_b), .MulStart(ms_b), .Fault(flt_b), .state_o(st_b));

  assign obs_a = {st_a, ir_a, adr_a, npc_a, regw_a, memw_a, br_a, aluop_a, sa_a, sb_a, rs_a,
                  mreq_a, ms_a, flt_a};
  assign obs_b = {st_b, ir_b, adr_b, npc_b, regw_b, memw_b, br_b, aluop_b, sa_b, sb_b, rs_b,
                  mreq_b, ms_b, flt_b};

  // Control table from the state description: expected outputs for a state.
  function automatic logic [19:0] exp_ctl(input logic [3:0] st, input bit rdy, input bit first);
    logic ir, adr, npc, regw, memw, br, aluop, mreq, ms, flt;
    logic [1:0] sa, sbx, rs;
    {ir, adr, npc, regw, memw, br, aluop, mreq, ms, flt} = '0;
    {sa, sbx, rs} = '0;
    case (st)
      4'd0:  begin mreq = 1; sa = 2'b01; sbx = 2'b10; rs = 2'b10; ir = rdy; npc = rdy; end
      4'd1:  begin sa = 2'b01; sbx = 2'b10; rs = 2'b10; end
      4'd2:  sbx = 2'b01;
      4'd3:  begin mreq = 1; adr = 1; end
      4'd4:  begin regw = 1; rs = 2'b01; end
      4'd5:  begin mreq = 1; adr = 1; memw = 1; end
      4'd6:  aluop = 1;
      4'd7:  begin sbx = 2'b01; aluop = 1; end
      4'd8:  regw = 1;
      4'd9:  begin br = 1; rs = 2'b10; sa = 2'b10; sbx = 2'b01; end
      4'd10: ms = first;
      4'd11: begin regw = 1; rs = 2'b11; end
      default: flt = 1;
    endcase
    return {st, ir, adr, npc, regw, memw, br, aluop, sa, sbx, rs, mreq, ms, flt};
  endfunction

  task automatic compare(input bit w, input string tag);
    logic [19:0] e, o;
    e = sb.pop_front();
    o = w ? obs_b : obs_a;
    ncmp++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Called just after a rising edge: expect outputs for this cycle, check at the falling edge.
  task automatic step(input bit w, input logic [3:0] st, input bit rdy, input bit first,
                      input string tag);
    sb.push_back(exp_ctl(st, rdy, first));
    @(negedge clk);
    compare(w, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input bit w, input logic [3:0] st, input bit rdy, input string tag);
    sb.push_back(exp_ctl(st, rdy, 1'b0));
    #1;
    compare(w, tag);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    Op = 2'b00; Funct = 6'd0; IsMul = 1'b0; mem_ready = 1'b0;
    #2;
    check_now(0, 4'd0, 1'b0, "reset_state");
    @(posedge clk); #1;
    rst_a = 1'b1;

    for (int i = 0; i < 3; i++) step(0, 4'd0, 1'b0, 1'b0, "fetch_wait");
    mem_ready = 1'b1;
    step(0, 4'd0, 1'b1, 1'b0, "fetch_ready");

    Op = 2'b01; Funct = 6'b000001;
    step(0, 4'd1, 1'b1, 1'b0, "ldr_decode");
    step(0, 4'd2, 1'b1, 1'b0, "ldr_memadr");
    step(0, 4'd3, 1'b1, 1'b0, "ldr_memrd");
    step(0, 4'd4, 1'b1, 1'b0, "ldr_memwb");
    step(0, 4'd0, 1'b1, 1'b0, "ldr_fetch");

    Op = 2'b00; Funct = 6'd0; IsMul = 1'b1;
    step(0, 4'd1, 1'b1, 1'b0, "mul_decode");
    step(0, 4'd10, 1'b1, 1'b1, "mulex_first");
    for (int i = 0; i < 3; i++) step(0, 4'd10, 1'b1, 1'b0, "mulex_hold");
    step(0, 4'd11, 1'b1, 1'b0, "mulwb");
    IsMul = 1'b0;
    step(0, 4'd0, 1'b1, 1'b0, "mul_fetch");

    Op = 2'b01; Funct = 6'b000001;
    step(0, 4'd1, 1'b1, 1'b0, "ldr2_decode");
    step(0, 4'd2, 1'b1, 1'b0, "ldr2_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step(0, 4'd3, 1'b0, 1'b0, "memrd_wait");
    mem_ready = 1'b1;
    step(0, 4'd3, 1'b1, 1'b0, "memrd_ready15");
    step(0, 4'd4, 1'b1, 1'b0, "memrd_late_wb");
    step(0, 4'd0, 1'b1, 1'b0, "ldr2_fetch");

    step(0, 4'd1, 1'b1, 1'b0, "ldr3_decode");
    step(0, 4'd2, 1'b1, 1'b0, "ldr3_memadr");
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step(0, 4'd3, 1'b0, 1'b0, "memrd_stuck");
    for (int i = 0; i < 22; i++) begin
      mem_ready = i[0];
      step(0, 4'd12, mem_ready, 1'b0, "fault_sticky");
    end

    mem_ready = 1'b1;
    rst_a = 1'b0;
    check_now(0, 4'd0, 1'b1, "fault_reset");
    @(posedge clk); #1;
    rst_a = 1'b1;
    step(0, 4'd0, 1'b1, 1'b0, "str_fetch");
    Op = 2'b01; Funct = 6'b000000;
    step(0, 4'd1, 1'b1, 1'b0, "str_decode");
    step(0, 4'd2, 1'b1, 1'b0, "str_memadr");
    mem_ready = 1'b0;
    step(0, 4'd5, 1'b0, 1'b0, "str_memwr_wait");
    step(0, 4'd5, 1'b0, 1'b0, "str_memwr_wait");
    rst_a = 1'b0;
    check_now(0, 4'd0, 1'b0, "reset_mid_memwr");
    @(posedge clk); #1;
    rst_a = 1'b1;
    step(0, 4'd0, 1'b0, 1'b0, "after_memwr_reset");

    mem_ready = 1'b1;
    step(0, 4'd0, 1'b1, 1'b0, "op11_fetch");
    Op = 2'b11;
    step(0, 4'd1, 1'b1, 1'b0, "op11_decode");
    step(0, 4'd12, 1'b1, 1'b0, "op11_fault");

    // Single-cycle memory instance: mem_ready held low must be ignored.
    mem_ready = 1'b0;
    rst_b = 1'b1;
    step(1, 4'd0, 1'b1, 1'b0, "nohs_fetch");
    Op = 2'b01; Funct = 6'b000000;
    step(1, 4'd1, 1'b1, 1'b0, "nohs_decode");
    step(1, 4'd2, 1'b1, 1'b0, "nohs_memadr");
    step(1, 4'd5, 1'b1, 1'b0, "nohs_memwr");
    Op = 2'b00;
    step(1, 4'd0, 1'b1, 1'b0, "nohs_fetch2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
